// File: rtl/adma_dm_src_axis.sv
// adma_dm_src_axis: DMA source stage forwarding exactly arlen+1 AXI-Stream beats per queued transaction.
// Define ADMA_SRC_AXIS_TKEEP_CHK_EN to flag accepted beats whose tkeep is not all-ones.
module adma_dm_src_axis #(
  parameter int DMA_CHN_NUM = 4,
  parameter int ATX_LEN_W = 8,
  parameter int ATX_SRC_DATA_W = 256,
  parameter int ATX_SRC_BYTE_AMT = ATX_SRC_DATA_W / 8,
  parameter int ATX_NUM_OSTD = DMA_CHN_NUM,
  localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [DMA_CHN_NUM_W-1:0]    atx_chn_id,
  input  logic [ATX_LEN_W-1:0]        atx_arlen,
  input  logic                        atx_vld,
  output logic                        atx_rdy,
  input  logic [ATX_SRC_DATA_W-1:0]   s_tdata_i,
  input  logic [ATX_SRC_BYTE_AMT-1:0] s_tkeep_i,
  input  logic                        s_tlast_i,
  input  logic                        s_tvalid_i,
  output logic                        s_tready_o,
  output logic [ATX_SRC_DATA_W-1:0]   atx_rdata,
  output logic                        atx_rdata_last,
  output logic                        atx_rdata_vld,
  input  logic                        atx_rdata_rdy,
  output logic [DMA_CHN_NUM-1:0]      atx_done,
  output logic [DMA_CHN_NUM-1:0]      atx_src_err
);
  localparam int AW = (ATX_NUM_OSTD > 1) ? $clog2(ATX_NUM_OSTD) : 1;
  localparam int CW = $clog2(ATX_NUM_OSTD + 1);
  typedef enum logic [1:0] {IDLE, XFER, PAD, DRAIN} state_t;
  state_t state, state_nxt;
  logic [DMA_CHN_NUM_W-1:0] chn_mem [ATX_NUM_OSTD];
  logic [ATX_LEN_W-1:0] len_mem [ATX_NUM_OSTD];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic push, pop, load, ld_last, err, slot_free, is_end;
  logic [ATX_SRC_DATA_W-1:0] ld_data;
  logic [ATX_LEN_W-1:0] cnt, cnt_nxt, cur_len;
  logic [DMA_CHN_NUM_W-1:0] cur_chn, out_chn;
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(ATX_NUM_OSTD - 1)) ? '0 : p + 1'b1;
  endfunction
  assign atx_rdy = fifo_cnt != CW'(ATX_NUM_OSTD);
  assign push = atx_vld & atx_rdy;
  assign cur_chn = chn_mem[rd_ptr];
  assign cur_len = len_mem[rd_ptr];
  assign slot_free = ~atx_rdata_vld | atx_rdata_rdy;
  assign is_end = cnt == cur_len;
  // done follows the channel captured with the output beat, not the FIFO head
  assign atx_done = (atx_rdata_vld & atx_rdata_rdy & atx_rdata_last) ? DMA_CHN_NUM'(1) << out_chn : '0;
`ifndef ADMA_SRC_AXIS_TKEEP_CHK_EN
  logic tkeep_unused;
  assign tkeep_unused = ^s_tkeep_i;
`endif
  always_comb begin
    state_nxt = state;
    s_tready_o = 1'b0;
    load = 1'b0;
    ld_data = '0;
    ld_last = 1'b0;
    cnt_nxt = cnt;
    pop = 1'b0;
    err = 1'b0;
    case (state)
      IDLE: state_nxt = (fifo_cnt != '0) ? XFER : IDLE;
      XFER: begin
        s_tready_o = slot_free;
        if (s_tvalid_i & slot_free) begin
          load = 1'b1;
          ld_data = s_tdata_i;
          ld_last = is_end;
          cnt_nxt = is_end ? '0 : cnt + 1'b1;
          pop = is_end;
          if (is_end & s_tlast_i) state_nxt = (fifo_cnt > CW'(1) | push) ? XFER : IDLE;
          else if (is_end | s_tlast_i) begin
            err = 1'b1;
            state_nxt = is_end ? DRAIN : PAD;
          end
`ifdef ADMA_SRC_AXIS_TKEEP_CHK_EN
          if (~&s_tkeep_i) err = 1'b1;
`endif
        end
      end
      PAD: begin
        if (slot_free) begin
          load = 1'b1;
          ld_last = is_end;
          cnt_nxt = is_end ? '0 : cnt + 1'b1;
          pop = is_end;
          state_nxt = is_end ? IDLE : PAD;
        end
      end
      DRAIN: begin
        s_tready_o = 1'b1;
        state_nxt = (s_tvalid_i & s_tlast_i) ? IDLE : DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (push) begin
      chn_mem[wr_ptr] <= atx_chn_id;
      len_mem[wr_ptr] <= atx_arlen;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_cnt <= '0;
      atx_rdata_vld <= 1'b0;
      atx_rdata <= '0;
      atx_rdata_last <= 1'b0;
      out_chn <= '0;
      atx_src_err <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (slot_free) atx_rdata_vld <= load;
      if (load) begin
        atx_rdata <= ld_data;
        atx_rdata_last <= ld_last;
        out_chn <= cur_chn;
      end
      atx_src_err <= err ? DMA_CHN_NUM'(1) << cur_chn : '0;
    end
  end
endmodule

// File: tb/tb_adma_dm_src_axis.sv
// tb_adma_dm_src_axis: directed self-checking bench for adma_dm_src_axis.
module tb_adma_dm_src_axis;
  logic aclk = 0, aresetn = 0;
  always #5 aclk = ~aclk;
  logic [1:0] atx_chn_id;
  logic [7:0] atx_arlen;
  logic atx_vld, atx_rdy;
  logic [255:0] s_tdata_i;
  logic [31:0] s_tkeep_i;
  logic s_tlast_i, s_tvalid_i, s_tready_o;
  logic [255:0] atx_rdata;
  logic atx_rdata_last, atx_rdata_vld, atx_rdata_rdy;
  logic [3:0] atx_done, atx_src_err;
  adma_dm_src_axis dut (
    .aclk(aclk), .aresetn(aresetn), .atx_chn_id(atx_chn_id), .atx_arlen(atx_arlen),
    .atx_vld(atx_vld), .atx_rdy(atx_rdy), .s_tdata_i(s_tdata_i), .s_tkeep_i(s_tkeep_i),
    .s_tlast_i(s_tlast_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
    .atx_rdata(atx_rdata), .atx_rdata_last(atx_rdata_last), .atx_rdata_vld(atx_rdata_vld),
    .atx_rdata_rdy(atx_rdata_rdy), .atx_done(atx_done), .atx_src_err(atx_src_err)
  );
  logic [255:0] src_d[$], out_d[$];
  logic src_l[$], out_l[$];
  logic [3:0] done_q[$], err_q[$];
  int out_cyc[$], done_cyc[$], err_cyc[$];
  int cyc = 0, last_hs_cyc = 0, viol = 0;
  bit bp_mode = 0;
  int checks = 0, passes = 0;
  always @(negedge aclk) begin
    if (aresetn) begin
      cyc <= cyc + 1;
      if (atx_rdata_vld & atx_rdata_rdy) begin
        out_d.push_back(atx_rdata);
        out_l.push_back(atx_rdata_last);
        out_cyc.push_back(cyc);
      end
      if (atx_done != 0) begin
        done_q.push_back(atx_done);
        done_cyc.push_back(cyc);
      end
      if (atx_src_err != 0) begin
        err_q.push_back(atx_src_err);
        err_cyc.push_back(cyc);
      end
      if (s_tvalid_i & s_tready_o & s_tlast_i) last_hs_cyc <= cyc;
      if (bp_mode & atx_rdata_vld & ~atx_rdata_rdy & s_tready_o) viol <= viol + 1;
    end
  end
  initial begin
    s_tvalid_i = 0;
    s_tdata_i = '0;
    s_tlast_i = 0;
    s_tkeep_i = '1;
    atx_rdata_rdy = 1;
    forever begin
      bit hs;
      @(negedge aclk);
      hs = s_tvalid_i & s_tready_o & aresetn;
      @(posedge aclk);
      #1;
      if (hs && src_d.size() != 0) begin
        src_d.delete(0);
        src_l.delete(0);
      end
      s_tvalid_i = src_d.size() != 0;
      s_tdata_i = s_tvalid_i ? src_d[0] : '0;
      s_tlast_i = s_tvalid_i ? src_l[0] : 1'b0;
      atx_rdata_rdy = bp_mode ? ~atx_rdata_rdy : 1'b1;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic logic [255:0] od(input int i);
    return (i < out_d.size()) ? out_d[i] : 'x;
  endfunction
  function automatic logic ol(input int i);
    return (i < out_l.size()) ? out_l[i] : 1'bx;
  endfunction
  function automatic logic [3:0] dq(input int i);
    return (i < done_q.size()) ? done_q[i] : 'x;
  endfunction
  function automatic logic [3:0] eq(input int i);
    return (i < err_q.size()) ? err_q[i] : 'x;
  endfunction
  task automatic clear();
    out_d.delete(); out_l.delete(); out_cyc.delete();
    done_q.delete(); done_cyc.delete(); err_q.delete(); err_cyc.delete();
  endtask
  task automatic settle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask
  task automatic beat(input logic [255:0] d, input logic l);
    src_d.push_back(d);
    src_l.push_back(l);
  endtask
  task automatic push_info(input int c, input int l);
    bit ok = 0;
    atx_chn_id = 2'(c);
    atx_arlen = 8'(l);
    atx_vld = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (atx_rdy) begin
        ok = 1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    atx_vld = 0;
    chk("push_accept", ok, 1);
  endtask
  initial begin
    atx_vld = 0;
    atx_chn_id = 0;
    atx_arlen = 0;
    @(negedge aclk);
    chk("rst_vld", atx_rdata_vld, 0);
    chk("rst_data", atx_rdata, 0);
    chk("rst_last", atx_rdata_last, 0);
    chk("rst_done_err", {atx_done, atx_src_err}, 0);
    chk("rst_tready", s_tready_o, 0);
    chk("rst_atx_rdy", atx_rdy, 1);
    @(posedge aclk);
    #1;
    aresetn = 1;
    settle(2);
    clear();
    push_info(1, 3);
    for (int i = 0; i < 4; i++) beat(256'h10 + 256'(i), i == 3);
    settle(15);
    chk("t1_n", out_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_d", od(i), 256'h10 + 256'(i));
      chk("t1_l", ol(i), i == 3);
    end
    chk("t1_done_n", done_q.size(), 1);
    chk("t1_done", dq(0), 4'b0010);
    chk("t1_done_lat", (done_cyc.size() != 0) ? done_cyc[0] - last_hs_cyc : -1, 1);
    chk("t1_err_n", err_q.size(), 0);
    clear();
    bp_mode = 1;
    push_info(0, 7);
    for (int i = 0; i < 8; i++) beat(256'h20 + 256'(i), i == 7);
    settle(30);
    bp_mode = 0;
    settle(2);
    chk("t2_n", out_d.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_d", od(i), 256'h20 + 256'(i));
      chk("t2_l", ol(i), i == 7);
    end
    chk("t2_tready_viol", viol, 0);
    chk("t2_done_n", done_q.size(), 1);
    chk("t2_done", dq(0), 4'b0001);
    chk("t2_err_n", err_q.size(), 0);
    clear();
    push_info(2, 5);
    for (int i = 0; i < 3; i++) beat(256'h30 + 256'(i), i == 2);
    settle(20);
    chk("t3_n", out_d.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t3_d", od(i), (i < 3) ? 256'h30 + 256'(i) : 256'h0);
      chk("t3_l", ol(i), i == 5);
    end
    chk("t3_err_n", err_q.size(), 1);
    chk("t3_err", eq(0), 4'b0100);
    chk("t3_done_n", done_q.size(), 1);
    chk("t3_done", dq(0), 4'b0100);
    clear();
    push_info(3, 1);
    push_info(0, 0);
    for (int i = 0; i < 4; i++) beat(256'h40 + 256'(i), i == 3);
    beat(256'h4f, 1);
    settle(20);
    chk("t4_n", out_d.size(), 3);
    chk("t4_d0", od(0), 256'h40);
    chk("t4_l0", ol(0), 0);
    chk("t4_d1", od(1), 256'h41);
    chk("t4_l1", ol(1), 1);
    chk("t4_d2", od(2), 256'h4f);
    chk("t4_l2", ol(2), 1);
    chk("t4_err_n", err_q.size(), 1);
    chk("t4_err", eq(0), 4'b1000);
    chk("t4_done_n", done_q.size(), 2);
    chk("t4_done0", dq(0), 4'b1000);
    chk("t4_done1", dq(1), 4'b0001);
    chk("t4_err_with_done", (err_cyc.size() != 0 && done_cyc.size() != 0) ? err_cyc[0] - done_cyc[0] : -1, 0);
    clear();
    push_info(0, 0);
    push_info(1, 0);
    push_info(2, 2);
    push_info(3, 0);
    @(negedge aclk);
    chk("t5_full", atx_rdy, 0);
    @(posedge aclk);
    #1;
    for (int i = 0; i < 6; i++) beat(256'h50 + 256'(i), i != 2 && i != 3);
    settle(20);
    chk("t5_n", out_d.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("t5_d", od(i), 256'h50 + 256'(i));
      chk("t5_l", ol(i), i != 2 && i != 3);
    end
    chk("t5_no_idle", (out_cyc.size() == 6) ? out_cyc[5] - out_cyc[0] : -1, 5);
    chk("t5_done_n", done_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("t5_done", dq(i), 4'b0001 << i);
    chk("t5_err_n", err_q.size(), 0);
    clear();
    push_info(0, 7);
    beat(256'h60, 0);
    beat(256'h61, 0);
    settle(10);
    chk("t6_pre_n", out_d.size(), 2);
    aresetn = 0;
    #1;
    chk("t6_rst_vld", atx_rdata_vld, 0);
    chk("t6_rst_data", atx_rdata, 0);
    chk("t6_rst_last", atx_rdata_last, 0);
    chk("t6_rst_done_err", {atx_done, atx_src_err}, 0);
    chk("t6_rst_tready", s_tready_o, 0);
    chk("t6_rst_atx_rdy", atx_rdy, 1);
    src_d.delete();
    src_l.delete();
    settle(2);
    aresetn = 1;
    settle(2);
    clear();
    push_info(1, 0);
    beat(256'h6f, 1);
    settle(10);
    chk("t6_n", out_d.size(), 1);
    chk("t6_d", od(0), 256'h6f);
    chk("t6_l", ol(0), 1);
    chk("t6_done_n", done_q.size(), 1);
    chk("t6_done", dq(0), 4'b0010);
    chk("t6_err_n", err_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
